// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One bit per clock: shift-add multiply, restoring divide, fixed WIDTH+2 latency.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]       state;
    logic [1:0]       op_r;       // bit1: divide, bit0: unsigned
    logic [WIDTH-1:0] a_r, b_r, b_mag, acc, q;
    logic [CW-1:0]    count;
    logic             sign_a, sign_b;

    logic             accept_idle, accept_md;
    logic             is_signed;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, hi_next, lo_next;

    assign busy        = (state != S_IDLE);
    assign ready       = ~busy;
    assign accept_idle = start && (state == S_IDLE);
    assign accept_md   = accept_idle && (op[2] == 1'b0);
    assign is_signed   = ~op_r[0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        div_shift = {acc, q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        prod_fix  = (sign_a ^ sign_b) ? -{acc, q} : {acc, q};
        quo_fix   = (sign_a ^ sign_b) ? -q : q;
        rem_fix   = sign_a ? -acc : acc;
        hi_next   = prod_fix[2*WIDTH-1:WIDTH];
        lo_next   = prod_fix[WIDTH-1:0];
        if (op_r[1]) begin
            if (div_by_zero) begin
                hi_next = a_r;
                lo_next = '1;
            end else begin
                hi_next = rem_fix;
                lo_next = quo_fix;
            end
        end
    end

    // Control state and architectural registers; reset aborts any operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= S_IDLE;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_md) begin
                        state       <= S_PREP;
                        div_by_zero <= op[1] && (b == '0);
                    end else if (accept_idle && op == OP_MTHI) begin
                        hi <= a;
                    end else if (accept_idle && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                S_PREP: begin
                    state <= S_RUN;
                    count <= CW'(WIDTH);
                end
                S_RUN: begin
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= S_FIX;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    hi    <= hi_next;
                    lo    <= lo_next;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM guarantees they are loaded before use.
    always_ff @(posedge clock) begin
        if (accept_md) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op[1:0];
        end
        case (state)
            S_PREP: begin
                sign_a <= is_signed && a_r[WIDTH-1];
                sign_b <= is_signed && b_r[WIDTH-1];
                q      <= (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
                b_mag  <= (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
                acc    <= '0;
            end
            S_RUN: begin
                if (op_r[1]) begin
                    // Restoring step: keep the subtraction only when it does not borrow.
                    if (!div_diff[WIDTH+1]) begin
                        acc <= div_diff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc <= mul_sum[WIDTH:1];
                    q   <= {mul_sum[0], q[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

endmodule
